// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU operation codes, MIPS
// opcode/funct values, the decoded-entry record and a few small helpers.
package alu_pkg;

    localparam logic [3:0] ALUC_ADD  = 4'd0;
    localparam logic [3:0] ALUC_ADDU = 4'd1;
    localparam logic [3:0] ALUC_SUB  = 4'd2;
    localparam logic [3:0] ALUC_SUBU = 4'd3;
    localparam logic [3:0] ALUC_AND  = 4'd4;
    localparam logic [3:0] ALUC_OR   = 4'd5;
    localparam logic [3:0] ALUC_XOR  = 4'd6;
    localparam logic [3:0] ALUC_NOR  = 4'd7;
    localparam logic [3:0] ALUC_SLT  = 4'd8;
    localparam logic [3:0] ALUC_SLTU = 4'd9;
    localparam logic [3:0] ALUC_SLL  = 4'd10;
    localparam logic [3:0] ALUC_SRL  = 4'd11;
    localparam logic [3:0] ALUC_SRA  = 4'd12;
    localparam logic [3:0] ALUC_LUI  = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // One decoded instruction as it travels through the skid buffer
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluc;
        logic        ovfTrapEn;
        logic        illegal;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic [31:0] signExt16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zeroExt16(input logic [15:0] imm);
        return {16'b0, imm};
    endfunction

    // Builds a legal (decodable) entry
    function automatic entry_t makeEntry(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] aluc, input logic ovfTrapEn);
        entry_t e;
        e.a         = a;
        e.b         = b;
        e.aluc      = aluc;
        e.ovfTrapEn = ovfTrapEn;
        e.illegal   = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake bus of the ALU issue stage: upstream valid/ready with the
// instruction and register data, downstream valid/ready with ALU operands.
interface alu_issue_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic        ovf_trap_en;
    logic        illegal;

    // View used by the issue stage itself
    modport slave (
        input  in_valid, instr, rs_data, rt_data, out_ready,
        output in_ready, out_valid, a, b, aluc, ovf_trap_en, illegal
    );

    // View used by the surrounding pipeline (register read + ALU)
    modport master (
        output in_valid, instr, rs_data, rt_data, out_ready,
        input  in_ready, out_valid, a, b, aluc, ovf_trap_en, illegal
    );

endinterface

// File: rtl/alu_issue_decode.sv
// Purely combinational decoder: MIPS instruction word plus rs/rt data
// into ALU operands, operation code and trap/illegal flags.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_ALUC = 4'd1
) (
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rsData,
    input  logic [31:0] i_rtData,
    output entry_t      o_entry
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [31:0] w_shamtExt;
    logic [31:0] w_rsShamtExt;
    logic        w_unusedFields;

    assign w_op           = i_instr[31:26];
    assign w_funct        = i_instr[5:0];
    assign w_imm          = i_instr[15:0];
    assign w_shamtExt     = {27'b0, i_instr[10:6]};
    assign w_rsShamtExt   = {27'b0, i_rsData[4:0]};
    assign w_unusedFields = ^i_instr[25:16];

    // Table decode; anything not listed falls through to the illegal entry with zero operands
    always_comb begin
        o_entry         = '0;
        o_entry.aluc    = ILLEGAL_ALUC;
        o_entry.illegal = 1'b1;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADD:   o_entry = makeEntry(i_rsData, i_rtData, ALUC_ADD, 1'b1);
                    F_ADDU:  o_entry = makeEntry(i_rsData, i_rtData, ALUC_ADDU, 1'b0);
                    F_SUB:   o_entry = makeEntry(i_rsData, i_rtData, ALUC_SUB, 1'b1);
                    F_SUBU:  o_entry = makeEntry(i_rsData, i_rtData, ALUC_SUBU, 1'b0);
                    F_AND:   o_entry = makeEntry(i_rsData, i_rtData, ALUC_AND, 1'b0);
                    F_OR:    o_entry = makeEntry(i_rsData, i_rtData, ALUC_OR, 1'b0);
                    F_XOR:   o_entry = makeEntry(i_rsData, i_rtData, ALUC_XOR, 1'b0);
                    F_NOR:   o_entry = makeEntry(i_rsData, i_rtData, ALUC_NOR, 1'b0);
                    F_SLT:   o_entry = makeEntry(i_rsData, i_rtData, ALUC_SLT, 1'b0);
                    F_SLTU:  o_entry = makeEntry(i_rsData, i_rtData, ALUC_SLTU, 1'b0);
                    F_SLL:   o_entry = makeEntry(w_shamtExt, i_rtData, ALUC_SLL, 1'b0);
                    F_SRL:   o_entry = makeEntry(w_shamtExt, i_rtData, ALUC_SRL, 1'b0);
                    F_SRA:   o_entry = makeEntry(w_shamtExt, i_rtData, ALUC_SRA, 1'b0);
                    F_SLLV:  o_entry = makeEntry(w_rsShamtExt, i_rtData, ALUC_SLL, 1'b0);
                    F_SRLV:  o_entry = makeEntry(w_rsShamtExt, i_rtData, ALUC_SRL, 1'b0);
                    F_SRAV:  o_entry = makeEntry(w_rsShamtExt, i_rtData, ALUC_SRA, 1'b0);
                    default: ;
                endcase
            end
            OP_ADDI:  o_entry = makeEntry(i_rsData, signExt16(w_imm), ALUC_ADD, 1'b1);
            OP_ADDIU: o_entry = makeEntry(i_rsData, signExt16(w_imm), ALUC_ADDU, 1'b0);
            OP_SLTI:  o_entry = makeEntry(i_rsData, signExt16(w_imm), ALUC_SLT, 1'b0);
            OP_SLTIU: o_entry = makeEntry(i_rsData, signExt16(w_imm), ALUC_SLTU, 1'b0);
            OP_ANDI:  o_entry = makeEntry(i_rsData, zeroExt16(w_imm), ALUC_AND, 1'b0);
            OP_ORI:   o_entry = makeEntry(i_rsData, zeroExt16(w_imm), ALUC_OR, 1'b0);
            OP_XORI:  o_entry = makeEntry(i_rsData, zeroExt16(w_imm), ALUC_XOR, 1'b0);
            OP_LUI:   o_entry = makeEntry(32'b0, zeroExt16(w_imm), ALUC_LUI, 1'b0);
            default:  ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the incoming instruction and holds results in a
// 2-entry skid buffer so the ALU side can stall without creating bubbles.
// in_ready is registered and depends only on the buffer fill, never on out_ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int         DEPTH        = 2,
    parameter logic [3:0] ILLEGAL_ALUC = 4'd1
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_stage_if.slave bus
);

    if (DEPTH != 2) begin : g_depthCheck
        $error("alu_issue_stage: DEPTH must be 2");
    end

    entry_t     w_dec;
    entry_t     w_head;
    entry_t     r_entry [2];
    logic [1:0] r_count;
    logic       r_head;
    logic       r_inReady;
    logic       w_push;
    logic       w_pop;
    logic       w_outValid;
    logic       w_tail;
    logic [1:0] w_countNext;

    alu_issue_decode #(
        .ILLEGAL_ALUC(ILLEGAL_ALUC)
    ) u_decode (
        .i_instr (bus.instr),
        .i_rsData(bus.rs_data),
        .i_rtData(bus.rt_data),
        .o_entry (w_dec)
    );

    assign w_outValid = (r_count != 2'd0);
    assign w_push     = bus.in_valid & r_inReady;
    assign w_pop      = w_outValid & bus.out_ready;
    assign w_tail     = r_head ^ (r_count == 2'd1);

    // Fill level after this cycle's transfers; push and pop together leave it unchanged
    always_comb begin
        w_countNext = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - 2'd1;
        end
    end

    // Buffer storage, head pointer, fill count and the registered ready flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_inReady  <= 1'b1;
        end else begin
            if (w_push) begin
                r_entry[w_tail] <= w_dec;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count   <= w_countNext;
            r_inReady <= (w_countNext != 2'd2);
        end
    end

    assign w_head          = r_entry[r_head];
    assign bus.in_ready    = r_inReady;
    assign bus.out_valid   = w_outValid;
    assign bus.a           = w_head.a;
    assign bus.b           = w_head.b;
    assign bus.aluc        = w_head.aluc;
    assign bus.ovf_trap_en = w_head.ovfTrapEn;
    assign bus.illegal     = w_head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluc;
        logic        ovf;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    logic armed;
    int   total;
    int   bad;
    exp_t modelQ[$];

    alu_issue_stage_if bus ();

    alu_issue_stage #(
        .DEPTH       (2),
        .ILLEGAL_ALUC(4'd1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode computed straight from the instruction tables
    function automatic exp_t refDecode(input logic [31:0] instr, input logic [31:0] rs,
                                       input logic [31:0] rt);
        exp_t r;
        int op;
        int fn;
        logic [15:0] imm;
        op = int'(instr[31:26]);
        fn = int'(instr[5:0]);
        imm = instr[15:0];
        r.a = 0; r.b = 0; r.aluc = 4'd1; r.ovf = 0; r.ill = 1;
        if (op == 0) begin
            if ((fn >= 'h20 && fn <= 'h27) || fn == 'h2A || fn == 'h2B) begin
                r.a = rs; r.b = rt; r.ill = 0;
                r.aluc = (fn <= 'h27) ? 4'(fn - 'h20) : 4'(fn - 'h2A + 8);
                r.ovf = (fn == 'h20 || fn == 'h22);
            end else if (fn == 0 || fn == 2 || fn == 3) begin
                r.a = {27'b0, instr[10:6]}; r.b = rt; r.ill = 0;
                r.aluc = (fn == 0) ? 4'd10 : 4'(fn - 1 + 10);
            end else if (fn == 4 || fn == 6 || fn == 7) begin
                r.a = {27'b0, rs[4:0]}; r.b = rt; r.ill = 0;
                r.aluc = (fn == 4) ? 4'd10 : 4'(fn - 5 + 10);
            end
        end else if (op >= 8 && op <= 'hB) begin
            r.a = rs; r.b = {{16{imm[15]}}, imm}; r.ill = 0;
            r.aluc = (op == 8) ? 4'd0 : (op == 9) ? 4'd1 : (op == 'hA) ? 4'd8 : 4'd9;
            r.ovf = (op == 8);
        end else if (op >= 'hC && op <= 'hE) begin
            r.a = rs; r.b = {16'b0, imm}; r.ill = 0;
            r.aluc = 4'(op - 'hC + 4);
        end else if (op == 'hF) begin
            r.a = 0; r.b = {16'b0, imm}; r.ill = 0; r.aluc = 4'd13;
        end
        return r;
    endfunction

    // One clock of the abstract FIFO: pop the oldest if consumed, append if accepted
    function automatic void modelStep(input bit iv, input bit ordy, input exp_t e);
        int sz;
        sz = modelQ.size();
        if (ordy && sz != 0) void'(modelQ.pop_front());
        if (iv && sz < 2) modelQ.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt, input bit ordy);
        @(negedge clk);
        #1;
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.rs_data   = rs;
        bus.rt_data   = rt;
        bus.out_ready = ordy;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        logic [5:0]  fnList [17];
        int pick;
        fnList = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                   6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01};
        r = $urandom;
        pick = $urandom_range(0, 15);
        if (pick <= 5) begin
            r[31:26] = 6'h00;
            r[5:0]   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fnList[$urandom_range(0, 16)];
        end else if (pick <= 13) begin
            r[31:26] = 6'(pick + 2);
        end else if (pick == 14) begin
            r[31:26] = 6'h23;
        end else begin
            r[31:26] = 6'($urandom);
        end
        return r;
    endfunction

    // Model advances on every rising edge using the same inputs the DUT sees
    always @(posedge clk) begin
        if (!rst_n) begin
            modelQ.delete();
            armed <= 1'b1;
        end else begin
            modelStep(bus.in_valid, bus.out_ready,
                      refDecode(bus.instr, bus.rs_data, bus.rt_data));
        end
    end

    // Compare DUT outputs against the model on every falling edge once reset has been seen
    always @(negedge clk) begin
        if (armed) begin
            checkOutput("out_valid", 32'(bus.out_valid), 32'(modelQ.size() != 0));
            checkOutput("in_ready", 32'(bus.in_ready), 32'(modelQ.size() < 2));
            if (modelQ.size() != 0) begin
                checkOutput("a", bus.a, modelQ[0].a);
                checkOutput("b", bus.b, modelQ[0].b);
                checkOutput("aluc", 32'(bus.aluc), 32'(modelQ[0].aluc));
                checkOutput("ovf_trap_en", 32'(bus.ovf_trap_en), 32'(modelQ[0].ovf));
                checkOutput("illegal", 32'(bus.illegal), 32'(modelQ[0].ill));
            end
        end
    end

    task automatic directWord(input string name, input logic [31:0] ins, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [31:0] expA,
                              input logic [31:0] expB, input logic [3:0] expAluc,
                              input bit expOvf, input bit expIll);
        applyStimulus(1'b1, ins, rs, rt, 1'b1);
        @(posedge clk);
        #1;
        checkOutput({name, ".valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({name, ".a"}, bus.a, expA);
        checkOutput({name, ".b"}, bus.b, expB);
        checkOutput({name, ".aluc"}, 32'(bus.aluc), 32'(expAluc));
        checkOutput({name, ".ovf"}, 32'(bus.ovf_trap_en), 32'(expOvf));
        checkOutput({name, ".ill"}, 32'(bus.illegal), 32'(expIll));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int outXfers;
        int notReady;
        int firstIdx;
        int lastIdx;
        total = 0;
        bad = 0;
        armed = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.instr = '0; bus.rs_data = '0; bus.rt_data = '0;
        bus.out_ready = 1'b0;

        // Reset with input offered: it must be ignored
        applyStimulus(1'b1, 32'h2000_0001, 32'h5, 32'h6, 1'b0);
        applyStimulus(1'b1, 32'h2000_0001, 32'h5, 32'h6, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst.in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst.a", bus.a, 32'd0);
        checkOutput("rst.b", bus.b, 32'd0);
        checkOutput("rst.aluc", 32'(bus.aluc), 32'd0);
        checkOutput("rst.flags", {30'd0, bus.ovf_trap_en, bus.illegal}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        rst_n = 1'b1;

        // Directed decode cases with literal expectations
        directWord("addi", {6'h08, 5'd1, 5'd2, 16'h0001}, 32'h7FFF_FFFF, 32'h1234,
                   32'h7FFF_FFFF, 32'h0000_0001, 4'd0, 1'b1, 1'b0);
        directWord("slti", {6'h0A, 5'd1, 5'd2, 16'hFFFF}, 32'h10, 32'h0,
                   32'h10, 32'hFFFF_FFFF, 4'd8, 1'b0, 1'b0);
        directWord("ori", {6'h0D, 5'd1, 5'd2, 16'hFFFF}, 32'h20, 32'h0,
                   32'h20, 32'h0000_FFFF, 4'd5, 1'b0, 1'b0);
        directWord("sll", {6'h00, 5'd0, 5'd2, 5'd3, 5'd5, 6'h00}, 32'hABCD, 32'h1,
                   32'h5, 32'h1, 4'd10, 1'b0, 1'b0);
        directWord("srav", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h07}, 32'h23, 32'h8000_0000,
                   32'h3, 32'h8000_0000, 4'd12, 1'b0, 1'b0);
        directWord("lw", {6'h23, 5'd1, 5'd2, 16'h0040}, 32'hDEAD, 32'hBEEF,
                   32'h0, 32'h0, 4'd1, 1'b0, 1'b1);
        directWord("sub", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 32'h9, 32'h4,
                   32'h9, 32'h4, 4'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Backpressure: three back-to-back ADDU words with the consumer stalled
        applyStimulus(1'b1, 32'h0000_0021, 32'h111, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0021, 32'h222, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0021, 32'h333, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("bp.in_ready_full", 32'(bus.in_ready), 32'd0);
        checkOutput("bp.head_a", bus.a, 32'h111);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("bp.frozen_a", bus.a, 32'h111);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("bp.second_a", bus.a, 32'h222);
        checkOutput("bp.in_ready_back", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp.drained", 32'(bus.out_valid), 32'd0);

        // Streaming: eight words with the consumer always ready
        outXfers = 0; notReady = 0; firstIdx = -1; lastIdx = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i < 8, randInstr(), $urandom, $urandom, 1'b1);
            if (bus.out_valid) begin
                outXfers++;
                if (firstIdx < 0) firstIdx = i;
                lastIdx = i;
            end
            if (i < 8 && !bus.in_ready) notReady++;
        end
        checkOutput("stream.outputs", 32'(outXfers), 32'd8);
        checkOutput("stream.consecutive", 32'(lastIdx - firstIdx), 32'd7);
        checkOutput("stream.in_ready_low", 32'(notReady), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randInstr(), $urandom, $urandom,
                          $urandom_range(0, 3) != 0);
        end

        // Reset while the buffer is full
        applyStimulus(1'b1, 32'h0000_0021, 32'h1, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0021, 32'h2, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0021, 32'h3, 32'h0, 1'b0);
        checkOutput("full.in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstfull.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstfull.in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randInstr(), $urandom, $urandom,
                          $urandom_range(0, 1) != 0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
